// File: rtl/result_display.sv
// Sequences slope, intercept and determinant onto a single seven-segment digit:
// a tag glyph, then tens and ones digits, then a blank gap, repeating per item.
module result_display #(
    parameter int unsigned RESULT_WIDTH = 12,
    parameter int unsigned HOLD_CYCLES  = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      done,
    input  logic [2*RESULT_WIDTH-1:0] C_packed,
    input  logic [RESULT_WIDTH-1:0]   det,
    input  logic                      error_det,
    input  logic                      error_values,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      busy,
    output logic                      ovf
);

    localparam int unsigned RW = RESULT_WIDTH;
    localparam int unsigned MW = RESULT_WIDTH + 1;
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TAG  = 3'd1,
        TENS = 3'd2,
        ONES = 3'd3,
        GAP  = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      item, item_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            load;
    logic [RW-1:0]   slope_q, icpt_q, det_q;

    logic [RW-1:0]   cur;
    logic [MW-1:0]   cur_ext, mag;
    logic            big;
    logic [3:0]      tens, ones;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'h3F;
            4'd1:    digit_glyph = 7'h06;
            4'd2:    digit_glyph = 7'h5B;
            4'd3:    digit_glyph = 7'h4F;
            4'd4:    digit_glyph = 7'h66;
            4'd5:    digit_glyph = 7'h6D;
            4'd6:    digit_glyph = 7'h7D;
            4'd7:    digit_glyph = 7'h07;
            4'd8:    digit_glyph = 7'h7F;
            4'd9:    digit_glyph = 7'h6F;
            default: digit_glyph = 7'h00;
        endcase
    endfunction

    // State, sequencing counters and latched results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            item    <= 2'd0;
            cnt     <= '0;
            slope_q <= '0;
            icpt_q  <= '0;
            det_q   <= '0;
        end else begin
            state <= state_nxt;
            item  <= item_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                slope_q <= C_packed[2*RW-1:RW];
                icpt_q  <= C_packed[RW-1:0];
                det_q   <= det;
            end
        end
    end

    // Errors outrank a restart, and a restart outranks the normal phase advance
    always_comb begin
        state_nxt = state;
        item_nxt  = item;
        cnt_nxt   = cnt;
        load      = 1'b0;
        if (error_values || (done && error_det)) begin
            state_nxt = ERR;
            item_nxt  = 2'd0;
            cnt_nxt   = '0;
        end else if (done) begin
            state_nxt = TAG;
            item_nxt  = 2'd0;
            cnt_nxt   = '0;
            load      = 1'b1;
        end else begin
            case (state)
                TAG, TENS, ONES, GAP: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        cnt_nxt = '0;
                        case (state)
                            TAG:     state_nxt = TENS;
                            TENS:    state_nxt = ONES;
                            ONES:    state_nxt = GAP;
                            default: begin
                                state_nxt = TAG;
                                item_nxt  = (item == 2'd2) ? 2'd0 : item + 2'd1;
                            end
                        endcase
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Display decode from registered state only
    always_comb begin
        case (item)
            2'd0:    cur = slope_q;
            2'd1:    cur = icpt_q;
            2'd2:    cur = det_q;
            default: cur = '0;
        endcase
        cur_ext = {cur[RW-1], cur};
        mag     = cur[RW-1] ? (MW'(0) - cur_ext) : cur_ext;
        big     = (mag > MW'(99));
        tens    = big ? 4'd9 : 4'(mag / MW'(10));
        ones    = big ? 4'd9 : 4'(mag % MW'(10));

        seg  = 7'h00;
        dp   = 1'b0;
        busy = 1'b0;
        ovf  = 1'b0;
        case (state)
            TAG: begin
                busy = 1'b1;
                dp   = cur[RW-1];
                ovf  = big;
                case (item)
                    2'd0:    seg = 7'h77;
                    2'd1:    seg = 7'h7C;
                    2'd2:    seg = 7'h5E;
                    default: seg = 7'h00;
                endcase
            end
            TENS: begin
                busy = 1'b1;
                dp   = cur[RW-1];
                ovf  = big;
                seg  = digit_glyph(tens);
            end
            ONES: begin
                busy = 1'b1;
                dp   = cur[RW-1];
                ovf  = big;
                seg  = digit_glyph(ones);
            end
            GAP:     busy = 1'b1;
            ERR:     seg  = 7'h79;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_result_display.sv
// Scoreboarded random test of result_display against a frame-list reference model.
module tb_result_display;

    localparam int RW   = 12;
    localparam int H    = 4;
    localparam int NFR  = 12 * H;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic       busy;
        logic       ovf;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           done;
    logic [2*RW-1:0] C_packed;
    logic [RW-1:0]  det;
    logic           error_det;
    logic           error_values;
    logic [6:0]     seg;
    logic           dp;
    logic           busy;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    // Reference model: a precomputed per-cycle frame list played back in a loop
    exp_t fr[NFR];
    int   mode = 0;  // 0 idle, 1 running, 2 error
    int   pos  = 0;
    logic [6:0] dg[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [6:0] tg[3]  = '{7'h77, 7'h7C, 7'h5E};

    result_display #(.RESULT_WIDTH(RW), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .C_packed(C_packed), .det(det),
        .error_det(error_det), .error_values(error_values),
        .seg(seg), .dp(dp), .busy(busy), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_load(input logic [2*RW-1:0] c, input logic [RW-1:0] d);
        int v[3];
        v[0] = int'($signed(c[2*RW-1:RW]));
        v[1] = int'($signed(c[RW-1:0]));
        v[2] = int'($signed(d));
        for (int it = 0; it < 3; it++) begin
            int m;
            bit neg, bg;
            int t, o;
            neg = (v[it] < 0);
            m   = neg ? -v[it] : v[it];
            bg  = (m > 99);
            t   = bg ? 9 : m / 10;
            o   = bg ? 9 : m % 10;
            for (int ph = 0; ph < 4; ph++) begin
                for (int k = 0; k < H; k++) begin
                    exp_t e;
                    e.busy = 1'b1;
                    e.dp   = (ph < 3) ? neg : 1'b0;
                    e.ovf  = (ph < 3) ? bg : 1'b0;
                    case (ph)
                        0:       e.seg = tg[it];
                        1:       e.seg = dg[t];
                        2:       e.seg = dg[o];
                        default: e.seg = 7'h00;
                    endcase
                    fr[it*4*H + ph*H + k] = e;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.seg = 7'h00; e.dp = 1'b0; e.busy = 1'b0; e.ovf = 1'b0;
        if (mode == 1) e = fr[pos];
        else if (mode == 2) e.seg = 7'h79;
        return e;
    endfunction

    // One clock of stimulus: drive before the edge, predict what follows it
    task automatic cyc(input logic rn, input logic dn, input logic ed, input logic ev,
                       input logic [2*RW-1:0] c, input logic [RW-1:0] d);
        @(negedge clk);
        rst_n = rn; done = dn; error_det = ed; error_values = ev; C_packed = c; det = d;
        if (!rn) mode = 0;
        else if (ev || (dn && ed)) mode = 2;
        else if (dn) begin model_load(c, d); mode = 1; pos = 0; end
        else if (mode == 1) pos = (pos + 1) % NFR;
        q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, C_packed, det);
    endtask

    task automatic check_now(input string name, input exp_t e);
        checks++;
        if (seg !== e.seg || dp !== e.dp || busy !== e.busy || ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s t=%0t got seg=%h dp=%b busy=%b ovf=%b want seg=%h dp=%b busy=%b ovf=%b",
                     name, $time, seg, dp, busy, ovf, e.seg, e.dp, e.busy, e.ovf);
        end
    endtask

    // Monitor: each cycle's settled outputs against the next scoreboard entry
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check_now("frame", q.pop_front());
        end
    end

    function automatic logic [RW-1:0] rnd_val();
        int s;
        s = int'($urandom_range(0, 9));
        if (s == 0) return RW'(-2048);
        if (s == 1) return RW'(2047);
        if (s < 4)  return RW'($urandom);
        return RW'(int'($urandom_range(0, 240)) - 120);
    endfunction

    initial begin
        exp_t z;
        z.seg = 7'h00; z.dp = 1'b0; z.busy = 1'b0; z.ovf = 1'b0;
        rst_n = 1'b0; done = 1'b0; error_det = 1'b0; error_values = 1'b0;
        C_packed = '0; det = '0;
        #1;
        check_now("reset_init", z);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Normal sequence: slope 3, intercept -12, det 25, two full loops
        cyc(1'b1, 1'b1, 1'b0, 1'b0, {RW'(3), RW'(-12)}, RW'(25));
        idle(2 * NFR);

        // Async reset in the TENS phase of the slope
        cyc(1'b1, 1'b1, 1'b0, 1'b0, {RW'(57), RW'(8)}, RW'(-99));
        idle(5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", z);
        mode = 0;
        q.push_back(model_out());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, C_packed, det);
        idle(3);

        // Overflow: slope 150, intercept -2048, det 100
        cyc(1'b1, 1'b1, 1'b0, 1'b0, {RW'(150), RW'(-2048)}, RW'(100));
        idle(NFR + 2);

        // Determinant error, recovery, then input error during ONES
        cyc(1'b1, 1'b1, 1'b1, 1'b0, {RW'(5), RW'(6)}, RW'(0));
        idle(6);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, {RW'(-7), RW'(42)}, RW'(-1));
        idle(9);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, C_packed, det);
        idle(5);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, {RW'(1), RW'(2)}, RW'(3));
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, {RW'(1), RW'(2)}, RW'(3));

        // Restart during the intercept's TENS phase
        idle(4 * H + H + 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, {RW'(-99), RW'(10)}, RW'(-100));
        idle(NFR);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic dn, ed, ev;
            dn = ($urandom_range(0, 29) == 0);
            ed = dn && ($urandom_range(0, 4) == 0);
            ev = ($urandom_range(0, 79) == 0);
            cyc(1'b1, dn, ed, ev, {rnd_val(), rnd_val()}, rnd_val());
        end

        @(negedge clk);
        done = 1'b0; error_values = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter RESULT_WIDTH, default 12: signed width of each result field.
REQ-002 Parameter HOLD_CYCLES, default 1000, minimum 2: number of cycles each display phase is held.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 done  input  1  one-cycle pulse from the regression pipeline: results are valid.
REQ-006 C_packed  input  2*RESULT_WIDTH  bits [RW-1:0] are the signed intercept; bits [2RW-1:RW] are the signed slope.
REQ-007 det  input  RESULT_WIDTH  signed determinant.
REQ-008 error_det  input  1  determinant is zero; sampled together with done.
REQ-009 error_values  input  1  input-entry error; live level.
REQ-010 seg  output  7  seven-segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-011 dp  output  1  sign indicator; 1 means the current value is negative.
REQ-012 busy  output  1  high while a display sequence is running.
REQ-013 ovf  output  1  high when the current item's magnitude exceeds 99.

Function
REQ-014 States: IDLE, TAG, TENS, ONES, GAP, ERR; a 2-bit item index selects 0=slope, 1=intercept, 2=det.
REQ-015 On a clk edge with done=1, and not in ERR-entry conditions, the block latches slope, intercept and det into holding registers, sets item=0, clears the hold counter and enters TAG.
REQ-016 Each of TAG, TENS, ONES and GAP lasts exactly HOLD_CYCLES cycles. The hold counter counts 0..HOLD_CYCLES-1, then wraps to 0 on the state advance.
REQ-017 Sequence: TAG -> TENS -> ONES -> GAP -> TAG of the next item. After GAP of item 2, the block returns to TAG with item 0 and loops until a new done, ERR, or reset.
REQ-018 A done arriving in any non-ERR state restarts per REQ-015 on that edge; the restart takes priority over the normal state advance.
REQ-019 Magnitude = |value|, computed at RESULT_WIDTH+1 bits so that the most negative input yields its true magnitude; tens = magnitude/10 and ones = magnitude%10.
REQ-020 If the magnitude exceeds 99, tens=9, ones=9 and ovf=1 for TAG/TENS/ONES of that item; otherwise ovf=0.
REQ-021 dp = sign bit of the current item during TAG/TENS/ONES; dp=0 in GAP, IDLE and ERR.
REQ-022 Digit glyphs (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-023 Tag glyphs: slope 'A'=77, intercept 'b'=7C, det 'd'=5E; error 'E'=79; blank=00.
REQ-024 seg shows blank in IDLE and GAP, the tag glyph in TAG, the tens digit in TENS, the ones digit in ONES, and 'E' in ERR.
REQ-025 seg, dp and ovf are decoded only from registered state and holding registers, never from live inputs.
REQ-026 busy=1 in TAG, TENS, ONES and GAP; busy=0 in IDLE and ERR.
REQ-027 ERR is entered on any edge where error_values=1 (highest priority, from any state), or where done=1 with error_det=1.
REQ-028 ERR is left only on an edge with done=1, error_det=0 and error_values=0, which proceeds per REQ-015.
REQ-029 Latency: the first tag glyph appears in the cycle immediately after the edge on which done is sampled.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, item=0, hold counter=0, holding registers=0, seg=00, dp=0, busy=0, ovf=0.
REQ-031 After rst_n deasserts, the block stays in IDLE until done or error_values.

Verification (HOLD_CYCLES=4)
REQ-032 Reset: assert rst_n=0 mid-TENS -> seg=00, dp=0, busy=0 and ovf=0 immediately, without waiting for a clock edge.
REQ-033 Normal sequence: slope=3, intercept=-12 (FF4), det=25, done pulse -> 4 cycles each of 77, 3F, 4F, 00 (busy=1), then 7C, 06, 5B with dp=1, then 00, 5E, 5B, 6D, 00, then 77 again.
REQ-034 Overflow: slope=150, done -> 77, 6F, 6F with ovf=1; -2048 displays 6F, 6F with dp=1 and ovf=1.
REQ-035 Errors: done with error_det=1 -> seg=79 steady and busy=0. A later done with no errors -> 77 on the next cycle. Raising error_values mid-ONES -> 79 on the next cycle.
REQ-036 Restart: a new done during the intercept's TENS phase -> next cycle shows 77 with the new data, and the hold counter restarts at 0.
